// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART frame constants and receiver state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int   UART_DATA_BITS     = 8;
    localparam logic UART_IDLE_LEVEL    = 1'b1;
    localparam logic UART_START_LEVEL   = 1'b0;
    localparam logic UART_TRAILER_LEVEL = 1'b0;

    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_START   = 2'd1,
        RX_DATA    = 2'd2,
        RX_TRAILER = 2'd3
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : First-word-fall-through FIFO; simultaneous push/pop honoured
//               even when full.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int             AW     = $clog2(DEPTH);
    localparam logic [AW:0]    C_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == C_FULL);
    assign w_do_pop   = pop_i && !empty_o;
    assign w_do_push  = push_i && (!full_o || w_do_pop);
    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : Oversampling UART receiver (MSB-first, trailing 0 bit) with
//               FWFT byte buffer and cts flow control.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver
    import uart_pkg::*;
#(
    parameter int SYMBOL_EDGE_TIME = 16,
    parameter int FIFO_DEPTH       = 4,
    parameter int SYNC_STAGES      = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      serial_in,
    output logic                      cts,
    output logic [UART_DATA_BITS-1:0] data_out,
    output logic                      data_out_valid,
    input  logic                      data_out_ready,
    output logic                      frame_error,
    output logic                      overrun,
    output logic                      rx_running
);

    localparam logic [31:0] C_HALF_BIT = 32'(SYMBOL_EDGE_TIME / 2 - 1);
    localparam logic [31:0] C_BIT_END  = 32'(SYMBOL_EDGE_TIME - 1);
    localparam int          IW         = $clog2(UART_DATA_BITS);

    logic [SYNC_STAGES-1:0]    sync_q;
    logic [SYNC_STAGES-1:0]    fill_q;
    logic                      w_s_in;
    logic                      w_s_in_real;
    rx_state_e                 state_q, state_d;
    logic [31:0]               cnt_q, cnt_d;
    logic [IW-1:0]             bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      armed_q, armed_d;
    logic                      frame_error_q, frame_error_d;
    logic                      overrun_q, overrun_d;
    logic                      cts_q, cts_d;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_full;
    logic                      w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_count;

    assign w_s_in = sync_q[SYNC_STAGES-1];
    // The synchronizer's reset value is not a line observation; ignore it for arming
    assign w_s_in_real = fill_q[SYNC_STAGES-1];

    assign w_pop          = !w_empty && data_out_ready;
    assign data_out_valid = !w_empty;
    assign rx_running     = (state_q != RX_IDLE);
    assign frame_error    = frame_error_q;
    assign overrun        = overrun_q;
    assign cts            = cts_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        armed_d       = armed_q;
        frame_error_d = 1'b0;
        overrun_d     = 1'b0;
        w_push        = 1'b0;
        if (state_q != RX_IDLE) begin
            cnt_d = cnt_q + 32'd1;
        end
        case (state_q)
            RX_IDLE: begin
                if (w_s_in_real && (w_s_in == UART_IDLE_LEVEL)) begin
                    armed_d = 1'b1;
                end else if (armed_q && (w_s_in == UART_START_LEVEL)) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == C_HALF_BIT) begin
                    cnt_d = '0;
                    if (w_s_in == UART_START_LEVEL) begin
                        state_d   = RX_DATA;
                        bit_idx_d = IW'(UART_DATA_BITS - 1);
                    end else begin
                        state_d = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (cnt_q == C_BIT_END) begin
                    cnt_d   = '0;
                    shift_d = {shift_q[UART_DATA_BITS-2:0], w_s_in};
                    if (bit_idx_q == '0) begin
                        state_d = RX_TRAILER;
                    end else begin
                        bit_idx_d = bit_idx_q - 1'b1;
                    end
                end
            end
            RX_TRAILER: begin
                if (cnt_q == C_BIT_END) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    armed_d = 1'b0;
                    if (w_s_in == UART_TRAILER_LEVEL) begin
                        if (!w_full || w_pop) begin
                            w_push = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Counting the in-flight frame keeps a slot reserved for it
    assign cts_d = (32'(w_count) + 32'(rx_running)) < 32'(FIFO_DEPTH);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q        <= {SYNC_STAGES{UART_IDLE_LEVEL}};
            fill_q        <= '0;
            state_q       <= RX_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            armed_q       <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
            cts_q         <= 1'b1;
        end else begin
            sync_q        <= {sync_q[SYNC_STAGES-2:0], serial_in};
            fill_q        <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            armed_q       <= armed_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
            cts_q         <= cts_d;
        end
    end

    uart_rx_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (w_push),
        .push_data_i (shift_q),
        .pop_i       (w_pop),
        .pop_data_o  (data_out),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .count_o     (w_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_receiver
// Description : Scoreboard bench for uart_receiver driven by a behavioural
//               transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    localparam int SET   = 16;
    localparam int DEPTH = 4;

    logic       clock          = 1'b0;
    logic       reset          = 1'b0;
    logic       serial_in      = 1'b1;
    logic       data_out_ready = 1'b0;
    logic       cts;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       frame_error;
    logic       overrun;
    logic       rx_running;

    int         checks       = 0;
    int         passed       = 0;
    int         fe_cnt       = 0;
    int         ov_cnt       = 0;
    int         valid_cycles = 0;
    int         pop_cnt      = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    always #5 clock = ~clock;

    uart_receiver #(
        .SYMBOL_EDGE_TIME (SET),
        .FIFO_DEPTH       (DEPTH),
        .SYNC_STAGES      (2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .serial_in      (serial_in),
        .cts            (cts),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .frame_error    (frame_error),
        .overrun        (overrun),
        .rx_running     (rx_running)
    );

    // Output monitor: pops the scoreboard on every consumer handshake
    always @(negedge clock) begin
        if (reset) begin
            if (frame_error) fe_cnt++;
            if (overrun) ov_cnt++;
            if (data_out_valid) valid_cycles++;
            if (data_out_valid && data_out_ready) begin
                checks++;
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL pop_unexpected: got %02h, expected no byte", data_out);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (data_out !== mon_exp)
                        $display("FAIL pop_data: got %02h, expected %02h", data_out, mon_exp);
                    else
                        passed++;
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic v);
        serial_in = v;
        cycles(SET);
    endtask

    task automatic tx_frame(input logic [7:0] b, input logic trailer, input bit expect_byte);
        if (expect_byte) exp_q.push_back(b);
        send_bit(1'b0);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        send_bit(trailer);
        send_bit(1'b1);
    endtask

    task automatic wait_cts(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (cts === 1'b1) begin
                ok = 1'b1;
                break;
            end
            cycles(1);
        end
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (exp_q.size() == 0 && data_out_valid === 1'b0) break;
            cycles(1);
        end
        checks++;
        if (exp_q.size() != 0 || data_out_valid !== 1'b0)
            $display("FAIL drain: got %0d pending valid=%b, expected 0 pending valid=0", exp_q.size(), data_out_valid);
        else
            passed++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cycles(3);
        checks++;
        if ({cts, data_out_valid, data_out, frame_error, overrun, rx_running} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_outputs: got cts=%b v=%b d=%02h fe=%b ov=%b run=%b, expected 1 0 00 0 0 0",
                     cts, data_out_valid, data_out, frame_error, overrun, rx_running);
        else
            passed++;
        reset = 1'b1;
        cycles(4);
        checks++;
        if (rx_running !== 1'b0 || cts !== 1'b1)
            $display("FAIL reset_release: got run=%b cts=%b, expected run=0 cts=1", rx_running, cts);
        else
            passed++;
    endtask

    task automatic test_single();
        int v0, fe0, ov0;
        data_out_ready = 1'b1;
        v0 = valid_cycles; fe0 = fe_cnt; ov0 = ov_cnt;
        tx_frame(8'hA5, 1'b0, 1'b1);
        cycles(5);
        checks++;
        if (valid_cycles - v0 != 1)
            $display("FAIL single_valid_cycles: got %0d, expected 1", valid_cycles - v0);
        else
            passed++;
        checks++;
        if (fe_cnt != fe0 || ov_cnt != ov0)
            $display("FAIL single_pulses: got fe=%0d ov=%0d, expected 0 0", fe_cnt - fe0, ov_cnt - ov0);
        else
            passed++;
        wait_drain(10);
    endtask

    task automatic test_glitch();
        int rise, fall, v0, fe0, ov0;
        rise = -1; fall = -1;
        v0 = valid_cycles; fe0 = fe_cnt; ov0 = ov_cnt;
        serial_in = 1'b0;
        cycles(3);
        serial_in = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (rx_running === 1'b1 && rise < 0) rise = i;
            if (rx_running === 1'b0 && rise >= 0 && fall < 0) fall = i;
            cycles(1);
        end
        checks++;
        if (rise < 0 || fall < 0 || fall - rise > 10)
            $display("FAIL glitch_running: got rise=%0d fall=%0d, expected a short high window", rise, fall);
        else
            passed++;
        checks++;
        if (valid_cycles != v0 || fe_cnt != fe0 || ov_cnt != ov0)
            $display("FAIL glitch_side_effects: got v=%0d fe=%0d ov=%0d, expected 0 0 0",
                     valid_cycles - v0, fe_cnt - fe0, ov_cnt - ov0);
        else
            passed++;
        tx_frame(8'h3C, 1'b0, 1'b1);
        wait_drain(10);
    endtask

    task automatic test_frame_error();
        int fe0, v0;
        data_out_ready = 1'b1;
        fe0 = fe_cnt; v0 = valid_cycles;
        tx_frame(8'h81, 1'b1, 1'b0);
        cycles(3);
        checks++;
        if (fe_cnt - fe0 != 1 || valid_cycles != v0)
            $display("FAIL frame_error: got fe=%0d valid=%0d, expected fe=1 valid=0", fe_cnt - fe0, valid_cycles - v0);
        else
            passed++;
        tx_frame(8'h55, 1'b0, 1'b1);
        wait_drain(10);
        checks++;
        if (fe_cnt - fe0 != 1)
            $display("FAIL frame_error_after_good: got %0d, expected 1", fe_cnt - fe0);
        else
            passed++;
    endtask

    task automatic test_flow_control();
        bit ok;
        int ov0, p0;
        data_out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            wait_cts(200, ok);
            checks++;
            if (!ok) $display("FAIL cts_before_frame%0d: got 0, expected 1", k);
            else passed++;
            tx_frame(8'(k), 1'b0, 1'b1);
        end
        cycles(2);
        checks++;
        if (cts !== 1'b0 || data_out_valid !== 1'b1 || data_out !== 8'h01)
            $display("FAIL flow_full: got cts=%b v=%b d=%02h, expected cts=0 v=1 d=01", cts, data_out_valid, data_out);
        else
            passed++;
        wait_cts(100, ok);
        checks++;
        if (ok) $display("FAIL flow_stall: got cts=1, expected cts held 0");
        else passed++;
        ov0 = ov_cnt;
        tx_frame(8'h99, 1'b0, 1'b0);
        cycles(2);
        checks++;
        if (ov_cnt - ov0 != 1)
            $display("FAIL overrun_pulse: got %0d, expected 1", ov_cnt - ov0);
        else
            passed++;
        p0 = pop_cnt;
        data_out_ready = 1'b1;
        wait_drain(20);
        checks++;
        if (pop_cnt - p0 != 4)
            $display("FAIL flow_pops: got %0d, expected 4", pop_cnt - p0);
        else
            passed++;
    endtask

    task automatic test_back_to_back();
        int v0, p0;
        data_out_ready = 1'b1;
        v0 = valid_cycles; p0 = pop_cnt;
        tx_frame(8'h10, 1'b0, 1'b1);
        tx_frame(8'h20, 1'b0, 1'b1);
        tx_frame(8'h30, 1'b0, 1'b1);
        wait_drain(10);
        checks++;
        if (pop_cnt - p0 != 3 || valid_cycles - v0 != 3)
            $display("FAIL b2b_counts: got pops=%0d valid=%0d, expected 3 3", pop_cnt - p0, valid_cycles - v0);
        else
            passed++;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        bit ran;
        b = 8'hC3;
        data_out_ready = 1'b0;
        tx_frame(8'h77, 1'b0, 1'b1);
        cycles(2);
        send_bit(1'b0);
        for (int i = 7; i >= 4; i--) send_bit(b[i]);
        serial_in = b[3];
        cycles(6);
        checks++;
        if (rx_running !== 1'b1 || data_out_valid !== 1'b1)
            $display("FAIL pre_reset: got run=%b v=%b, expected 1 1", rx_running, data_out_valid);
        else
            passed++;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({cts, data_out_valid, data_out, frame_error, overrun, rx_running} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0})
            $display("FAIL async_reset: got cts=%b v=%b d=%02h fe=%b ov=%b run=%b, expected 1 0 00 0 0 0",
                     cts, data_out_valid, data_out, frame_error, overrun, rx_running);
        else
            passed++;
        exp_q.delete();
        serial_in = 1'b0;
        cycles(2);
        reset = 1'b1;
        ran = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycles(1);
            if (rx_running !== 1'b0) ran = 1'b1;
        end
        checks++;
        if (ran) $display("FAIL low_line_after_reset: got rx_running=1, expected 0");
        else passed++;
        serial_in = 1'b1;
        cycles(SET);
        data_out_ready = 1'b1;
        tx_frame(8'hC3, 1'b0, 1'b1);
        wait_drain(10);
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_error();
        test_flow_control();
        test_back_to_back();
        test_reset_mid_frame();
        cycles(5);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel receiver that consumes the line driven by uart_transmitter and delivers bytes to the fabric.
- Frame format: idle high; start bit 0; 8 data bits MSB-first; one trailing bit at 0; line returns high.
- Incoming bytes are buffered in a small FIFO and presented on a valid/ready interface.
- The block drives cts back to the transmitter for flow control.

Parameters:
SYMBOL_EDGE_TIME, 16, clocks per bit; must be ≥4 and must equal the transmitter's value (868 for 100 MHz/115200).
FIFO_DEPTH, 4, received-byte buffer entries; power of 2, ≥2.
SYNC_STAGES, 2, input synchronizer flops; ≥2.

Ports:
clock  in  1  sole clock
reset  in  1  one clock; reset is asynchronous and active-low
serial_in  in  1  line from transmitter serial_out
cts  out  1  high = receiver can accept a whole new frame
data_out  out  8  head-of-FIFO byte
data_out_valid  out  1  FIFO non-empty
data_out_ready  in  1  consumer pop strobe; pop when valid&ready
frame_error  out  1  1-cycle pulse: trailing bit sampled 1, byte dropped
overrun  out  1  1-cycle pulse: good frame completed with FIFO full, byte dropped
rx_running  out  1  high in START/DATA/TRAILER

Behaviour:
Reset:
- All flops cleared asynchronously.
- Synchronizer flops reset to 1 (idle level).
- Outputs at reset: cts=1, data_out_valid=0, data_out=0, frame_error=0, overrun=0, rx_running=0.
- armed=0 after reset.

Input path:
- serial_in passes through SYNC_STAGES flops, giving s_in.
- Fixed latency of SYNC_STAGES cycles; no other filtering.

Bit counter:
- 32-bit, cleared on every state entry.
- Increments each cycle while in START/DATA/TRAILER.

armed flag:
- Set whenever s_in==1 in IDLE.
- Cleared on entry to IDLE from TRAILER and by reset.
- Prevents the trailing 0 or a stuck-low line from being taken as a start bit.

State machine (IDLE, START, DATA, TRAILER):
- IDLE: if armed and s_in==0, go to START with counter=0.
- START: at counter == SYMBOL_EDGE_TIME/2 − 1, sample s_in (mid start bit).
  - 0: go to DATA, bit_idx=7, counter=0.
  - 1: glitch; go to IDLE with no pulse and armed kept.
- DATA: at counter == SYMBOL_EDGE_TIME − 1, sample s_in.
  - shift <= {shift[6:0], s_in}.
  - If bit_idx==0, go to TRAILER; else decrement bit_idx.
  - Counter resets at every sample.
- TRAILER: at counter == SYMBOL_EDGE_TIME − 1, sample s_in.
  - 0: frame good. Push shift if FIFO has room (count<DEPTH, or a pop occurs the same cycle); else pulse overrun.
  - 1: pulse frame_error, no push.
  - In both cases go to IDLE with armed=0.

Flow control:
- cts = (count + rx_running) < FIFO_DEPTH, registered.
- Guarantees a frame started under cts=1 always has a slot.
- overrun only occurs if the transmitter ignores cts.

FIFO:
- First-word-fall-through.
- Push from TRAILER becomes visible on data_out/data_out_valid the next cycle.
- Simultaneous push and pop are both honoured and count is unchanged. This applies when full and when count==1.
- Pop when empty is ignored.
- Pointers wrap modulo FIFO_DEPTH; count is clog2(FIFO_DEPTH)+1 bits.

Latency: a byte is available SYNC_STAGES+1 cycles after the transmitter's trailing-bit midpoint sample point.

Reset mid-frame: partial byte discarded, FIFO emptied, no pulses; reception resumes only after s_in seen high.

Decomposition:
Shared package uart_pkg holds:
- UART_DATA_BITS=8
- UART_IDLE_LEVEL=1'b1
- UART_START_LEVEL=1'b0
- UART_TRAILER_LEVEL=1'b0
- 2-bit rx state encodings IDLE/START/DATA/TRAILER

Sub-module: uart_rx_fifo (parameterised width/depth, push/pop/full/empty/count). It is reusable by a future TX-side buffer.

Test Plan:
1. SYMBOL_EDGE_TIME=16: uart_transmitter sends 0xA5 into serial_in, ready=1 → data_out_valid=1 for one cycle with data_out=0xA5, no error pulses, FIFO empty afterwards.
2. Drive serial_in low for 3 clocks from idle → rx_running rises then falls by counter 7, no push, no pulses, then 0x3C frame received correctly.
3. Hand-drive frame 0x81 with trailing bit 1 → frame_error single pulse, data_out_valid stays 0, next frame 0x55 received OK.
4. ready=0, transmitter sends 0x01..0x04 with cts honoured → cts=0 after 4th frame starts, transmitter stalls. Force a 5th frame ignoring cts → overrun pulse. Then pop 4 → 0x01,0x02,0x03,0x04 in order.
5. Hold ready=1 with back-to-back frames 0x10,0x20,0x30 → push/pop collisions keep count ≤1, all bytes delivered in order.
6. Assert reset at DATA bit_idx=3 → all outputs at reset values asynchronously. Release with line low → no start detected until line high, then 0xC3 received correctly.
